// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the state encoding used by RX, TX and benches.
package uart_pkg;

    localparam int unsigned UART_OS_RATE = 16;
    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_MID     = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synced value.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign rx_fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: 1 start, 8 data LSB-first, 1 parity, 1 stop.
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each mid-bit sample, decided one clock later.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter logic        PARITY_MODE = 1'b0,
    parameter int unsigned OS_RATE     = UART_OS_RATE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] dataout,
    output logic                   rdsig,
    output logic                   dataerror,
    output logic                   frameerror,
    output logic                   idle
);

    localparam int unsigned MID = OS_RATE / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned OFS = MID + 1;
`else
    localparam int unsigned OFS = MID;
`endif

    logic                   rx_s;
    logic                   rx_fall;
    uart_state_e            state;
    uart_state_e            state_n;
    logic [7:0]             cnt;
    logic [7:0]             target;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   perr;
    logic                   bit_val;
    logic                   hit;
    logic                   do_shift;
    logic                   do_par;
    logic                   do_stop;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist[0]/hist[1] hold the synced line one and two clocks back, so at MID+1 they are the MID and MID-1 samples
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '1;
        else        hist <= {hist[0], rx_s};
    end

    assign bit_val = majority3(hist[1], hist[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        case (state)
            ST_DATA:   target = 8'(OFS + OS_RATE * (32'(bit_idx) + 1));
            ST_PARITY: target = 8'(OFS + OS_RATE * 9);
            ST_STOP:   target = 8'(OFS + OS_RATE * 10);
            default:   target = 8'(OFS);
        endcase
    end

    assign hit = (cnt == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        do_par   = 1'b0;
        do_stop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fall) state_n = ST_START;
            end
            ST_START: begin
                if (hit) state_n = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (hit) begin
                    do_shift = 1'b1;
                    if (bit_idx == 3'(UART_DATA_W - 1)) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (hit) begin
                    do_par  = 1'b1;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (hit) begin
                    do_stop = 1'b1;
                    state_n = bit_val ? ST_IDLE : ST_BRK;
                end
            end
            ST_BRK: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // cnt is 0 in the cycle the edge is seen and holds in BRK so it cannot wrap while the line stays low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            dataout    <= '0;
            rdsig      <= 1'b0;
            dataerror  <= 1'b0;
            frameerror <= 1'b0;
            idle       <= 1'b0;
        end else begin
            if (state_n == ST_IDLE)  cnt <= '0;
            else if (state != ST_BRK) cnt <= cnt + 8'd1;

            if (state != ST_DATA) bit_idx <= '0;
            else if (do_shift)    bit_idx <= bit_idx + 3'd1;

            if (do_shift) shreg <= {bit_val, shreg[UART_DATA_W-1:1]};
            if (do_par)   perr  <= bit_val ^ (^shreg) ^ PARITY_MODE;

            if (do_stop) begin
                dataout    <= shreg;
                dataerror  <= perr;
                frameerror <= ~bit_val;
            end
            rdsig <= do_stop;
            idle  <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of clean/parity-error frames plus break, glitch, back-to-back and reset sequences.
module tb_uart_rx_os16;
    import uart_pkg::*;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT = 172;
`else
    localparam int LAT = 171;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;
    logic       idle;

    always #5 clk = ~clk;

    uart_rx_os16 #(.PARITY_MODE(1'b0), .OS_RATE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .dataout    (dataout),
        .rdsig      (rdsig),
        .dataerror  (dataerror),
        .frameerror (frameerror),
        .idle       (idle)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       derr;
        logic       ferr;
    } strobe_t;

    strobe_t caps[$];
    int      doubles = 0;
    int      idle_hi = 0;
    logic    rd_prev = 1'b0;

    always @(negedge clk) begin
        if (rdsig) caps.push_back('{dataout, cyc, dataerror, frameerror});
        if (rdsig && rd_prev) doubles++;
        rd_prev = rdsig;
        if (idle) idle_hi++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; each bit is held 16 clocks, optional 1-clock inversion at offset 8 of one bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int glitch_bit, output int fall_cyc);
        logic [10:0] bits;
        bits     = {s, p, d, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            if (i == glitch_bit) begin
                repeat (8) @(negedge clk);
                rx = ~bits[i];
                @(negedge clk);
                rx = bits[i];
                repeat (7) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_strobe(input string name, input int idx, input logic [7:0] d,
                              input logic derr, input logic ferr);
        strobe_t c;
        c = caps[idx];
        chk({name, "_data"}, 32'(c.data), 32'(d));
        chk({name, "_derr"}, 32'(c.derr), 32'(derr));
        chk({name, "_ferr"}, 32'(c.ferr), 32'(ferr));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic [7:0] exp_data;
        logic       exp_derr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n0;
        int i0;
        int fc;
        int fc2;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dataout", 32'(dataout), 32'h0);
        chk("rst_rdsig", 32'(rdsig), 32'h0);
        chk("rst_dataerror", 32'(dataerror), 32'h0);
        chk("rst_frameerror", 32'(frameerror), 32'h0);
        chk("rst_idle", 32'(idle), 32'h0);
        rst_n = 1'b1;
        idle_line(5);

        for (int v = 0; v < 5; v++) begin
            n0 = caps.size();
            i0 = idle_hi;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stp, -1, fc);
            idle_line(20);
            chk($sformatf("vec%0d_strobes", v), 32'(caps.size() - n0), 32'd1);
            if (caps.size() > n0) begin
                chk($sformatf("vec%0d_latency", v), 32'(caps[n0].cyc - fc), 32'(LAT));
                chk_strobe($sformatf("vec%0d", v), n0, vecs[v].exp_data, vecs[v].exp_derr, vecs[v].exp_ferr);
            end
            chk($sformatf("vec%0d_busy", v), 32'((idle_hi - i0) >= 160 && (idle_hi - i0) <= 175), 32'd1);
            chk($sformatf("vec%0d_idle_after", v), 32'(idle), 32'h0);
        end

        // stop bit low: break held 40 clocks then released
        n0 = caps.size();
        send_frame(8'h3C, 1'b0, 1'b0, -1, fc);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("brk_idle_held", 32'(idle), 32'h1);
        chk("brk_strobes", 32'(caps.size() - n0), 32'd1);
        if (caps.size() > n0) chk_strobe("brk", n0, 8'h3C, 1'b0, 1'b1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("brk_idle_release", 32'(idle), 32'h0);
        chk("brk_no_second", 32'(caps.size() - n0), 32'd1);
        idle_line(10);

        // 4-clock low pulse is rejected at the start sample
        n0 = caps.size();
        i0 = idle_hi;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_line(30);
        chk("glitch_strobes", 32'(caps.size() - n0), 32'd0);
        chk("glitch_busy_seen", 32'((idle_hi - i0) > 0), 32'd1);
        chk("glitch_idle_after", 32'(idle), 32'h0);

        // back-to-back frames, no idle gap
        n0 = caps.size();
        send_frame(8'h55, 1'b0, 1'b1, -1, fc);
        send_frame(8'hAA, 1'b0, 1'b1, -1, fc2);
        idle_line(20);
        chk("b2b_strobes", 32'(caps.size() - n0), 32'd2);
        if (caps.size() >= n0 + 2) begin
            chk("b2b_gap", 32'(caps[n0 + 1].cyc - caps[n0].cyc), 32'd176);
            chk("b2b_latency2", 32'(caps[n0 + 1].cyc - fc2), 32'(LAT));
            chk_strobe("b2b_first", n0, 8'h55, 1'b0, 1'b0);
            chk_strobe("b2b_second", n0 + 1, 8'hAA, 1'b0, 1'b0);
        end

        // reset around cnt=80 of a frame
        n0 = caps.size();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (66) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_dataout", 32'(dataout), 32'h0);
        chk("midrst_rdsig", 32'(rdsig), 32'h0);
        chk("midrst_dataerror", 32'(dataerror), 32'h0);
        chk("midrst_frameerror", 32'(frameerror), 32'h0);
        chk("midrst_idle", 32'(idle), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_line(10);
        chk("midrst_no_strobe", 32'(caps.size() - n0), 32'd0);
        n0 = caps.size();
        send_frame(8'hF0, 1'b0, 1'b1, -1, fc);
        idle_line(20);
        chk("postrst_strobes", 32'(caps.size() - n0), 32'd1);
        if (caps.size() > n0) begin
            chk("postrst_latency", 32'(caps[n0].cyc - fc), 32'(LAT));
            chk_strobe("postrst", n0, 8'hF0, 1'b0, 1'b0);
        end

`ifdef UART_RX_MAJORITY_VOTE_EN
        // single-clock inversion at the mid-bit of data bit 2 (frame bit 3) is outvoted
        n0 = caps.size();
        send_frame(8'h5A, 1'b0, 1'b1, 3, fc);
        idle_line(20);
        chk("vote_strobes", 32'(caps.size() - n0), 32'd1);
        if (caps.size() > n0) chk_strobe("vote", n0, 8'h5A, 1'b0, 1'b0);
`endif

        chk("rdsig_width", 32'(doubles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
